// File: rtl/router_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : router_out_fifo
// Purpose  : Per-output-port byte FIFO of the 1x3 router with header tagging
//            and read-side packet tracking.
// Revision : 1.0 - initial release
// ============================================================================
module router_out_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              pkt_active
);

    localparam logic [ADDR_W:0]   c_PTR_ONE = 1;
    localparam logic [DATA_W-2:0] c_PKT_ONE = 1;

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [DATA_W-2:0] pkt_count_q, pkt_count_d;

    logic              w_full;
    logic              w_empty;
    logic              w_do_wr;
    logic              w_do_rd;
    logic              w_clear;
    logic [DATA_W:0]   w_rd_entry;

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                     (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign w_do_wr = write_enb && !w_full;
    assign w_do_rd = read_enb && !w_empty;
    assign w_clear = !resetn || soft_reset;
    assign w_rd_entry = mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        data_out_d  = data_out_q;
        pkt_count_d = pkt_count_q;
        if (w_do_wr) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_do_rd) begin
            rd_ptr_d   = rd_ptr_q + c_PTR_ONE;
            data_out_d = w_rd_entry[DATA_W-1:0];
            // A header reloads the count even mid-packet: payload length plus parity.
            if (w_rd_entry[DATA_W]) begin
                pkt_count_d = {1'b0, w_rd_entry[DATA_W-1:2]} + c_PKT_ONE;
            end else if (pkt_count_q != '0) begin
                pkt_count_d = pkt_count_q - c_PKT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            data_out_q  <= '0;
            pkt_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            data_out_q  <= data_out_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Storage is never cleared; a flush only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (w_do_wr && !w_clear) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

    assign data_out   = data_out_q;
    assign full       = w_full;
    assign empty      = w_empty;
    assign pkt_active = (pkt_count_q != '0);

endmodule
`default_nettype wire
